// File: rtl/wiz_bus_cycle.sv
// Bus-cycle engine between the QL expansion-bus decoder and the W5300: syncs the
// 68008 strobes, sequences CS/RD/WR with programmable timing and requests DTACK.
module wiz_bus_cycle #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic wizsel,
    input  logic dsl,
    input  logic rdwl,
    output logic wizcsl,
    output logic wizrdl,
    output logic wizwrl,
    output logic dtack_req,
    output logic busy,
    output logic abort
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
        HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_param
        $error("wiz_bus_cycle: cycle parameters must lie in 1..15");
    end

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, ACK, HOLD} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       rd_lat, rd_lat_nxt;
    logic       armed, start, abort_nxt;
    logic       dsl_m, dsl_s, sel_m, sel_s, rd_m, rd_s;
    logic [1:0] sync_vld;
    logic       csl_nxt, rdl_nxt, wrl_nxt, dtack_nxt, busy_nxt;

    // sync_vld keeps the reset value of dsl_s from arming a cycle: a DS that is
    // already low when reset drops must be seen high once before it counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsl_m    <= 1'b1;
            dsl_s    <= 1'b1;
            sel_m    <= 1'b0;
            sel_s    <= 1'b0;
            rd_m     <= 1'b1;
            rd_s     <= 1'b1;
            sync_vld <= '0;
        end else begin
            dsl_m    <= dsl;
            dsl_s    <= dsl_m;
            sel_m    <= wizsel;
            sel_s    <= sel_m;
            rd_m     <= rdwl;
            rd_s     <= rd_m;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_lat    <= 1'b1;
            armed     <= 1'b0;
            wizcsl    <= 1'b1;
            wizrdl    <= 1'b1;
            wizwrl    <= 1'b1;
            dtack_req <= 1'b0;
            busy      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rd_lat    <= rd_lat_nxt;
            if (start)
                armed <= 1'b0;
            else if (sync_vld[1] && dsl_s)
                armed <= 1'b1;
            wizcsl    <= ~csl_nxt;
            wizrdl    <= ~rdl_nxt;
            wizwrl    <= ~wrl_nxt;
            dtack_req <= dtack_nxt;
            busy      <= busy_nxt;
            abort     <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rd_lat_nxt = rd_lat;
        start      = 1'b0;
        abort_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (armed && sel_s && !dsl_s) begin
                    state_nxt  = SETUP;
                    rd_lat_nxt = rd_s;
                    cnt_nxt    = '0;
                    start      = 1'b1;
                end
            end
            SETUP: begin
                // DS release beats counter expiry so DTACK is never raised late
                if (dsl_s) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    abort_nxt = 1'b1;
                end else if (cnt == SETUP_LAST) begin
                    state_nxt = STROBE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            STROBE: begin
                if (dsl_s) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    abort_nxt = 1'b1;
                end else if (cnt == STROBE_LAST) begin
                    state_nxt = ACK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            ACK: begin
                if (dsl_s) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every strobe leaves a flop.
    // Writes end on entry to ACK: the W5300 latches data on the rising WR edge.
    always_comb begin
        csl_nxt   = (state_nxt != IDLE);
        busy_nxt  = (state_nxt != IDLE);
        rdl_nxt   = rd_lat_nxt && (state_nxt == STROBE || state_nxt == ACK);
        wrl_nxt   = !rd_lat_nxt && (state_nxt == STROBE);
        dtack_nxt = (state_nxt == ACK);
    end

endmodule

// File: tb/tb_wiz_bus_cycle.sv
// Bench for wiz_bus_cycle: two instances (default and stretched timing) share
// stimulus; expectations come from a per-transaction timeline model.
module tb_wiz_bus_cycle;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wizsel = 1'b0;
    logic dsl = 1'b1;
    logic rdwl = 1'b1;

    logic csl0, rdl0, wrl0, dt0, busy0, ab0;
    logic csl1, rdl1, wrl1, dt1, busy1, ab1;
    logic [5:0] o0, o1;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    localparam int SC [2] = '{1, 3};
    localparam int TC [2] = '{4, 15};
    localparam int HC [2] = '{1, 2};
    localparam logic [5:0] IDLE_OUT = 6'b111000;

    always #5 clk = ~clk;

    wiz_bus_cycle dut0 (
        .clk(clk), .rst(rst), .wizsel(wizsel), .dsl(dsl), .rdwl(rdwl),
        .wizcsl(csl0), .wizrdl(rdl0), .wizwrl(wrl0),
        .dtack_req(dt0), .busy(busy0), .abort(ab0)
    );

    wiz_bus_cycle #(.SETUP_CYC(3), .STROBE_CYC(15), .HOLD_CYC(2)) dut1 (
        .clk(clk), .rst(rst), .wizsel(wizsel), .dsl(dsl), .rdwl(rdwl),
        .wizcsl(csl1), .wizrdl(rdl1), .wizwrl(wrl1),
        .dtack_req(dt1), .busy(busy1), .abort(ab1)
    );

    assign o0 = {csl0, rdl0, wrl0, dt0, busy0, ab0};
    assign o1 = {csl1, rdl1, wrl1, dt1, busy1, ab1};

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Timeline of one DS assertion: t0 = cycle start, h = HOLD entry (DS
    // release seen), a = when DTACK would be due. Abort iff release comes first.
    function automatic logic [5:0] exp_out(int t0, int h, bit rd, bit sel,
                                           int s, int t, int hc, int k);
        int  a;
        bit  ab;
        logic csl, rdl, wrl, dt, bz, abp;
        if (!sel) return IDLE_OUT;
        a   = t0 + s + t;
        ab  = (h <= a);
        bz  = (k >= t0) && (k < h + hc);
        csl = !bz;
        rdl = !(rd && k >= t0 + s && k < h);
        wrl = !(!rd && k >= t0 + s && k < h && k < a);
        dt  = !ab && k >= a && k < h;
        abp = ab && (k == h);
        return {csl, rdl, wrl, dt, bz, abp};
    endfunction

    // One DS-low period of lo_len edges; twist drops wizsel and flips rdwl
    // right after the cycle has started.
    task automatic test_txn(input string name, input int lo_len, input bit rd,
                            input bit sel, input bit twist);
        int f, u, t0, h;
        logic [5:0] e, got;
        wizsel = sel;
        rdwl   = rd;
        dsl    = 1'b1;
        repeat (3) tick();
        f  = cyc + 1;
        u  = f + lo_len;
        t0 = f + 2;
        h  = u + 2;
        dsl = 1'b0;
        for (int k = f; k <= u + 6; k++) begin
            if (k == u) dsl = 1'b1;
            tick();
            if (twist && k == t0) begin
                wizsel = 1'b0;
                rdwl   = !rd;
            end
            for (int d = 0; d < 2; d++) begin
                e   = exp_out(t0, h, rd, sel, SC[d], TC[d], HC[d], k);
                got = (d == 0) ? o0 : o1;
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL %s dut%0d edge f+%0d: got %b want %b (csl,rdl,wrl,dtack,busy,abort)",
                             name, d, k - f, got, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        vectors += 2;
        if (o0 !== IDLE_OUT) begin
            miscompares++;
            $display("FAIL reset dut0: got %b want %b", o0, IDLE_OUT);
        end
        if (o1 !== IDLE_OUT) begin
            miscompares++;
            $display("FAIL reset dut1: got %b want %b", o1, IDLE_OUT);
        end
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_read();
        test_txn("read", 10, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_write();
        test_txn("write", 10, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        test_txn("abort_strobe", 3, 1'b1, 1'b1, 1'b0);
        test_txn("abort_setup", 1, 1'b0, 1'b1, 1'b0);
        test_txn("short_ds", 2, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_unselected();
        test_txn("unsel_long", 8, 1'b1, 1'b0, 1'b0);
        test_txn("unsel_short", 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_late();
        test_txn("late_sel_rdwl_w", 12, 1'b0, 1'b1, 1'b1);
        test_txn("late_sel_rdwl_r", 25, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_sweep();
        test_txn("sweep_write", 30, 1'b0, 1'b1, 1'b0);
        test_txn("sweep_read", 30, 1'b1, 1'b1, 1'b0);
        test_txn("sweep_edge", 18, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        wizsel = 1'b1;
        rdwl   = 1'b1;
        dsl    = 1'b1;
        repeat (3) tick();
        dsl = 1'b0;
        repeat (4) tick();
        vectors++;
        if (o0 !== 6'b001010) begin
            miscompares++;
            $display("FAIL pre_reset_strobe dut0: got %b want %b", o0, 6'b001010);
        end
        rst = 1'b1;
        tick();
        vectors += 2;
        if (o0 !== IDLE_OUT) begin
            miscompares++;
            $display("FAIL reset_mid dut0: got %b want %b", o0, IDLE_OUT);
        end
        if (o1 !== IDLE_OUT) begin
            miscompares++;
            $display("FAIL reset_mid dut1: got %b want %b", o1, IDLE_OUT);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors += 2;
            if (o0 !== IDLE_OUT || o1 !== IDLE_OUT) begin
                miscompares++;
                $display("FAIL no_rearm cyc %0d: got %b/%b want %b", i, o0, o1, IDLE_OUT);
            end
        end
        test_txn("after_reset", 9, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++)
            test_txn("random", int'($urandom_range(1, 30)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_abort();
        test_unselected();
        test_ignore_late();
        test_sweep();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
